// File: rtl/riscv_fetch_pkg.sv
// Shared fetch-stage types and constants.
package riscv_fetch_pkg;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  // Width of the count of responses still owed by imem for flushed slots.
  localparam int DROP_W = 8;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        filled;
  } fetch_entry_t;

  // Instruction addresses are always word aligned.
  function automatic logic [31:0] align_pc(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/inst_fetch_unit_if.sv
// Fetch-stage bus: imem request/response, redirect, and decode handoff.
// Handshake rule for every valid/ready pair below: a transfer happens on a
// rising edge where valid && ready are both high; once raised, valid and its
// payload stay stable until that transfer (redirect may retract a request).
// imem_rsp_valid and redirect_valid have no ready and are consumed on sight.
interface inst_fetch_unit_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_inst;
  logic [31:0] id_pc;

  modport master (
    output imem_req_valid, imem_req_addr, id_valid, id_inst, id_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
    input  redirect_valid, redirect_pc, id_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, id_valid, id_inst, id_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
    output redirect_valid, redirect_pc, id_ready
  );
endinterface

// File: rtl/fetch_buf.sv
// Circular buffer of fetch entries. A slot is allocated when its request is
// accepted, filled in order when the response returns, and popped in order.
// Allocation (tail) and fill run on separate pointers; flush frees everything.
module fetch_buf
  import riscv_fetch_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          alloc,
  input  logic [31:0]   alloc_pc,
  input  logic          fill,
  input  logic [31:0]   fill_inst,
  input  logic          pop,
  output fetch_entry_t  head,
  output logic          head_valid,
  output logic [CW-1:0] count,
  output logic [CW-1:0] unfilled
);

  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] fill_ptr;
  logic [CW-1:0] fcount;
  logic          fill_ok;

  // A response with no unfilled slot to land in is ignored.
  assign fill_ok    = fill && (unfilled != '0);
  assign unfilled   = count - fcount;
  assign head       = mem[rd_ptr];
  assign head_valid = mem[rd_ptr].filled && (count != '0);

  // Slot storage, pointers and occupancy counters.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      fill_ptr <= '0;
      count    <= '0;
      fcount   <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i].filled <= 1'b0;
    end else begin
      if (alloc) begin
        mem[wr_ptr].pc     <= alloc_pc;
        mem[wr_ptr].filled <= 1'b0;
        wr_ptr             <= wr_ptr + PW'(1);
      end
      if (fill_ok) begin
        mem[fill_ptr].inst   <= fill_inst;
        mem[fill_ptr].filled <= 1'b1;
        fill_ptr             <= fill_ptr + PW'(1);
      end
      if (pop) begin
        mem[rd_ptr].filled <= 1'b0;
        rd_ptr             <= rd_ptr + PW'(1);
      end
      count  <= count + CW'(alloc) - CW'(pop);
      fcount <= fcount + CW'(fill_ok) - CW'(pop);
    end
  end

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: PC, in-order imem requests, response buffering,
// decode handoff and redirect flush.
// Optional build macro IFETCH_PERF_EN adds perf_fetched / perf_flushed counters.
module inst_fetch_unit
  import riscv_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  inst_fetch_unit_if.master ifu
`ifdef IFETCH_PERF_EN
  ,
  output logic [31:0]       perf_fetched,
  output logic [31:0]       perf_flushed
`endif
);

  localparam int CW   = $clog2(BUF_DEPTH) + 1;
  localparam int DS_W = DROP_W + 1;

  logic [31:0]       pc;
  logic [DROP_W-1:0] drop_cnt;
  logic [DS_W-1:0]   drop_sum;
  logic [31:0]       hold_inst;
  logic [31:0]       hold_pc;
  fetch_entry_t      head;
  logic              head_valid;
  logic [CW-1:0]     buf_count;
  logic [CW-1:0]     buf_unfilled;
  logic              buf_full;
  logic              req_fire;
  logic              rsp_fill;
  logic              pop;

  assign buf_full           = (buf_count == CW'(BUF_DEPTH));
  assign ifu.imem_req_valid = !reset && !buf_full && !ifu.redirect_valid;
  assign ifu.imem_req_addr  = pc;
  assign req_fire           = ifu.imem_req_valid && ifu.imem_req_ready;
  assign rsp_fill           = ifu.imem_rsp_valid && (drop_cnt == '0) && !ifu.redirect_valid;
  assign ifu.id_valid       = head_valid;
  assign pop                = head_valid && ifu.id_ready;
  // When empty, decode keeps seeing the last instruction that was shown.
  assign ifu.id_inst        = head_valid ? head.inst : hold_inst;
  assign ifu.id_pc          = head_valid ? head.pc   : hold_pc;

  fetch_buf #(.DEPTH(BUF_DEPTH)) u_buf (
    .clk        (clk),
    .reset      (reset),
    .flush      (ifu.redirect_valid),
    .alloc      (req_fire),
    .alloc_pc   (pc),
    .fill       (rsp_fill),
    .fill_inst  (ifu.imem_rsp_data),
    .pop        (pop),
    .head       (head),
    .head_valid (head_valid),
    .count      (buf_count),
    .unfilled   (buf_unfilled)
  );

  // Responses still owed after a redirect: those already being dropped plus
  // every unfilled slot, less the one arriving this cycle (never below zero).
  always_comb begin
    drop_sum = {1'b0, drop_cnt} + DS_W'(buf_unfilled) + DS_W'(req_fire);
    if (ifu.imem_rsp_valid && (drop_sum != '0)) drop_sum = drop_sum - DS_W'(1);
  end

  // PC and drop counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc       <= RESET_PC;
      drop_cnt <= '0;
    end else if (ifu.redirect_valid) begin
      pc       <= align_pc(ifu.redirect_pc);
      drop_cnt <= drop_sum[DROP_W] ? '1 : drop_sum[DROP_W-1:0];
    end else begin
      if (req_fire) pc <= pc + 32'd4;
      if (ifu.imem_rsp_valid && (drop_cnt != '0)) drop_cnt <= drop_cnt - DROP_W'(1);
    end
  end

  // Remember the last presented instruction for the empty case.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_inst <= NOP_INST;
      hold_pc   <= RESET_PC;
    end else if (head_valid) begin
      hold_inst <= head.inst;
      hold_pc   <= head.pc;
    end
  end

`ifdef IFETCH_PERF_EN
  // Pops delivered, and live slots discarded by redirect (a same-cycle pop survives).
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetched <= '0;
      perf_flushed <= '0;
    end else begin
      if (pop) perf_fetched <= perf_fetched + 32'd1;
      if (ifu.redirect_valid)
        perf_flushed <= perf_flushed + 32'(buf_count) - 32'(pop);
    end
  end
`endif

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit: directed scenarios followed by randomized traffic,
// checked against a queue-based model of the fetch stream.
module tb_inst_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 2;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  logic clk = 1'b0;
  logic reset;
  inst_fetch_unit_if bus();
`ifdef IFETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_flushed;
`endif

  inst_fetch_unit #(.RESET_PC(RESET_PC), .BUF_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .ifu   (bus)
`ifdef IFETCH_PERF_EN
    ,
    .perf_fetched (perf_fetched),
    .perf_flushed (perf_flushed)
`endif
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;

  logic [63:0] exp_q[$];   // {pc, inst} expected at decode, oldest first
  pend_t       pend_q[$];  // imem requests awaiting a response
  logic [31:0] m_pc;
  logic [31:0] last_inst;
  logic [31:0] last_pc;
  logic        expect_idle;
  int          lat_min = 1;
  int          lat_max = 1;
  int          m_fetched = 0;
  int          m_flushed = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- imem responder ----------------
  always @(posedge clk) begin
    #1;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = 32'h0;
    if (pend_q.size() != 0 && pend_q[0].due <= cyc) begin
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = mem_word(pend_q[0].addr);
      void'(pend_q.pop_front());
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      pend_q.delete();
      m_pc        = RESET_PC;
      last_inst   = NOP;
      last_pc     = RESET_PC;
      expect_idle = 1'b0;
      m_fetched   = 0;
      m_flushed   = 0;
    end else begin
      check("req_valid_rule", 32'(bus.imem_req_valid),
            32'((exp_q.size() < DEPTH) && !bus.redirect_valid));
      if (expect_idle) begin
        check("idle_after_redirect", 32'(bus.id_valid), 32'd0);
        expect_idle = 1'b0;
      end
      if (bus.id_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_id_valid", 32'(bus.id_valid), 32'd0);
        end else begin
          check("id_pc", bus.id_pc, exp_q[0][63:32]);
          check("id_inst", bus.id_inst, exp_q[0][31:0]);
          last_pc   = exp_q[0][63:32];
          last_inst = exp_q[0][31:0];
          if (bus.id_ready) begin
            void'(exp_q.pop_front());
            m_fetched++;
          end
        end
      end else begin
        check("hold_inst", bus.id_inst, last_inst);
        check("hold_pc", bus.id_pc, last_pc);
      end
      if (bus.imem_req_valid && bus.imem_req_ready) begin
        check("req_addr", bus.imem_req_addr, m_pc);
        pend_q.push_back('{addr: m_pc, due: cyc + $urandom_range(lat_min, lat_max)});
        exp_q.push_back({m_pc, mem_word(m_pc)});
        m_pc = m_pc + 32'd4;
      end
      if (bus.redirect_valid) begin
        m_flushed += exp_q.size();
        exp_q.delete();
        m_pc        = bus.redirect_pc & ~32'h3;
        expect_idle = 1'b1;
      end
    end
  end

  // ---------------- driver ----------------
  initial begin
    bit found;
    reset              = 1'b1;
    bus.imem_req_ready = 1'b1;
    bus.id_ready       = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = 32'h0;
    repeat (3) tick();

    // 1: reset release, streaming with 1-cycle imem
    reset = 1'b0;
    @(negedge clk);
    check("t1_first_req_valid", 32'(bus.imem_req_valid), 32'd1);
    check("t1_first_req_addr", bus.imem_req_addr, RESET_PC);
    check("t1_id_valid_t0", 32'(bus.id_valid), 32'd0);
    @(negedge clk);
    check("t1_id_valid_t1", 32'(bus.id_valid), 32'd0);
    @(negedge clk);
    check("t1_id_valid_t2", 32'(bus.id_valid), 32'd1);
    check("t1_id_pc_t2", bus.id_pc, RESET_PC);
    repeat (12) tick();

    // 2: decode stalled from reset -> buffer fills, then drains in order
    reset = 1'b1; bus.id_ready = 1'b0;
    tick();
    reset = 1'b0;
    repeat (5) tick();
    @(negedge clk);
    check("t2_full_no_req", 32'(bus.imem_req_valid), 32'd0);
    tick();
    bus.id_ready = 1'b1;
    @(negedge clk);
    check("t2_pop0_pc", bus.id_pc, 32'h0);
    @(negedge clk);
    check("t2_pop1_valid", 32'(bus.id_valid), 32'd1);
    check("t2_pop1_pc", bus.id_pc, 32'h4);
    repeat (8) tick();

    // 3: imem stalls; request address must stay put (low redirect bits ignored)
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h13; bus.imem_req_ready = 1'b0;
    tick();
    bus.redirect_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t3_req_valid", 32'(bus.imem_req_valid), 32'd1);
      check("t3_req_addr", bus.imem_req_addr, 32'h10);
      check("t3_no_alloc", 32'(bus.id_valid), 32'd0);
    end
    tick();
    bus.imem_req_ready = 1'b1;
    repeat (6) tick();

    // 4: redirect with two requests in flight on a slow imem
    lat_min = 3; lat_max = 3;
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h200;
    tick();
    bus.redirect_valid = 1'b0;
    repeat (2) tick();
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h100;
    tick();
    bus.redirect_valid = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge clk);
      found = bus.id_valid;
    end
    check("t4_valid_seen", 32'(found), 32'd1);
    check("t4_first_pc", bus.id_pc, 32'h100);
    check("t4_first_inst", bus.id_inst, mem_word(32'h100));
    lat_min = 1; lat_max = 1;
    repeat (8) tick();

    // 5: redirect in the same cycle as a pop
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      found = bus.id_valid;
    end
    check("t5_valid_seen", 32'(found), 32'd1);
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h300;
    @(negedge clk);
    check("t5_no_req_on_redirect", 32'(bus.imem_req_valid), 32'd0);
    tick();
    bus.redirect_valid = 1'b0;
    @(negedge clk);
    check("t5_no_valid_next", 32'(bus.id_valid), 32'd0);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      found = bus.id_valid;
    end
    check("t5_restart_pc", bus.id_pc, 32'h300);
    repeat (4) tick();

    // 6: reset with a full buffer
    bus.id_ready = 1'b0;
    repeat (5) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("t6_id_valid", 32'(bus.id_valid), 32'd0);
    check("t6_id_inst", bus.id_inst, NOP);
    check("t6_id_pc", bus.id_pc, RESET_PC);
    check("t6_req_valid", 32'(bus.imem_req_valid), 32'd1);
    check("t6_req_addr", bus.imem_req_addr, RESET_PC);
`ifdef IFETCH_PERF_EN
    check("t6_perf_fetched", perf_fetched, 32'd0);
    check("t6_perf_flushed", perf_flushed, 32'd0);
`endif
    tick();
    bus.id_ready = 1'b1;

    // random traffic, including PC wrap and back-to-back redirects
    for (int n = 0; n < 3000; n++) begin
      tick();
      if (n % 200 == 0) lat_max = $urandom_range(1, 3);
      bus.imem_req_ready = ($urandom_range(0, 3) != 0);
      bus.id_ready       = ($urandom_range(0, 3) != 0);
      bus.redirect_valid = ($urandom_range(0, 19) == 0);
      bus.redirect_pc    = ($urandom_range(0, 3) == 0) ?
                           (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom();
      reset              = ($urandom_range(0, 399) == 0);
    end
    tick();
    reset = 1'b0; bus.redirect_valid = 1'b0; bus.id_ready = 1'b1; bus.imem_req_ready = 1'b1;
    repeat (20) tick();
`ifdef IFETCH_PERF_EN
    @(negedge clk);
    check("perf_fetched", perf_fetched, 32'(m_fetched));
    check("perf_flushed", perf_flushed, 32'(m_flushed));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
